mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit for the EX stage, alongside the ALU. Its results are consumed by the EX/MEM register via MFHI/MFLO. It accepts MULT, MULTU, DIV and DIVU with fixed multi-cycle latency, holding a busy flag that the hazard unit uses to stall ID. It also performs single-cycle MTHI and MTLO writes and presents the architectural HI and LO registers at all times.

## Interface
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  EX-stage instruction is an MD-class op this cycle
- mdOp  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- opA  input  32  rs operand (forwarded value)
- opB  input  32  rt operand (forwarded value)
- busy  output  1  long operation in progress
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

## Operation
- State: IDLE, RUN. Down-counter cnt is sized for max(MULT_CYCLES, DIV_CYCLES). Result latches resHi and resLo.
- IDLE, start=1, mdOp in 1..4:
  - Compute the result from opA/opB at that edge and latch it into resHi/resLo.
  - Load cnt with N (MULT_CYCLES or DIV_CYCLES).
  - Go to RUN.
- IDLE, start=1, mdOp=5: hi ← opA at that edge; no busy.
- IDLE, start=1, mdOp=6: lo ← opA at that edge; no busy.
- IDLE, mdOp 0 or 7, or start=0: no state change.
- RUN: cnt decrements each edge. At the edge where cnt reaches 0:
  - hi ← resHi, lo ← resLo.
  - Go to IDLE.
- start while in RUN (any mdOp) is ignored. The hazard unit guarantees this never happens, but the block must not corrupt state.
- hi/lo keep their old values throughout RUN.
- Arithmetic:
  - MULT: signed 32×32 → 64-bit product; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32×32 → 64-bit product; same split.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - 0x80000000 DIV 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero (DIV or DIVU, opB = 0): the unit still goes busy for DIV_CYCLES. hi and lo are left unchanged at completion.
- Operands are captured at start. Changes on opA/opB during RUN have no effect.
- reset at any time, including mid-RUN:
  - Aborts the operation immediately.
  - hi = 0, lo = 0, busy = 0, cnt = 0, state IDLE.
  - The pending result is discarded.

## Timing
- Reset values: busy = 0, hi = 0x00000000, lo = 0x00000000.
- busy is registered, equal to (state == RUN).
- For a long op sampled at edge E:
  - busy = 1 from just after E through edge E+N, i.e. exactly N cycles high.
  - hi/lo take the new values at edge E+N, the same edge at which busy falls.
- A new long op may be sampled on the first cycle with busy = 0, i.e. at edge E+N+1. Back-to-back ops therefore have zero idle gap.
- MTHI/MTLO: the value is visible on hi/lo the cycle after the sampling edge.
- The hazard unit must stall ID when (busy | start&(mdOp∈1..4)) and the ID instruction is MD-class. The block does not generate the stall itself.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then MULT with opA = 0xFFFFFFFF, opB = 0x00000002:
  - busy high exactly 5 cycles.
  - Afterwards hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
  - hi/lo stay 0 while busy.
- MULTU with opA = 0xFFFFFFFF, opB = 0x00000002: hi = 0x00000001, lo = 0xFFFFFFFE after 5 cycles.
- DIV with opA = 0xFFFFFFF9 (−7), opB = 2:
  - busy 10 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - Follow with DIVU 7/0: busy 10 cycles, then hi/lo unchanged.
  - Follow with DIV 0x80000000/0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on the next cycle:
  - busy stays 0.
  - hi and lo update one cycle after their respective edges.
  - Then issue MULT 3×4 with opA/opB toggling randomly during RUN: result hi = 0, lo = 12.
- DIVU started, then a MULT and an MTLO presented with start = 1 while busy: both are ignored, and only the DIVU result lands.
  - Next, a MULT issued on the first cycle busy = 0: it is accepted with zero gap.
- Assert reset asynchronously mid-way through a DIV (cycle 4 of 10):
  - busy, hi and lo go to 0 immediately, without waiting for a clock edge.
  - After release, the aborted result never appears, and a new MULT completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: MD-class op request and architectural HI/LO result bundle.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, mdOp, opA, opB, input busy, hi, lo);
  modport slave (input start, mdOp, opA, opB, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO, holding HI/LO.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mult_div_unit_if.slave md
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] res_hi, res_lo, hi, lo, res_hi_n, res_lo_n, hi_n, lo_n;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] ua, ub, q, r, quot, rem;
  logic sgn, is_mul, long_op, dz;
  assign long_op = md.start && (md.mdOp inside {3'd1, 3'd2, 3'd3, 3'd4});
  assign is_mul = md.mdOp == 3'd1 || md.mdOp == 3'd2;
  assign prod_s = $signed(md.opA) * $signed(md.opB);
  assign prod_u = {32'd0, md.opA} * {32'd0, md.opB};
  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign sgn = md.mdOp == 3'd3;
  assign dz = md.opB == 32'd0;
  assign ua = (sgn && md.opA[31]) ? -md.opA : md.opA;
  assign ub = (sgn && md.opB[31]) ? -md.opB : md.opB;
  assign q = dz ? 32'd0 : ua / ub;
  assign r = dz ? 32'd0 : ua % ub;
  assign quot = (sgn && (md.opA[31] ^ md.opB[31])) ? -q : q;
  assign rem = (sgn && md.opA[31]) ? -r : r;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    res_hi_n = res_hi;
    res_lo_n = res_lo;
    hi_n = hi;
    lo_n = lo;
    if (state == IDLE) begin
      if (long_op) begin
        state_n = RUN;
        cnt_n = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        res_hi_n = md.mdOp == 3'd1 ? prod_s[63:32] : md.mdOp == 3'd2 ? prod_u[63:32] : dz ? hi : rem;
        res_lo_n = md.mdOp == 3'd1 ? prod_s[31:0] : md.mdOp == 3'd2 ? prod_u[31:0] : dz ? lo : quot;
      end
      hi_n = (md.start && md.mdOp == 3'd5) ? md.opA : hi;
      lo_n = (md.start && md.mdOp == 3'd6) ? md.opA : lo;
    end else begin
      cnt_n = cnt - 1'b1;
      state_n = cnt == CW'(1) ? IDLE : RUN;
      hi_n = cnt == CW'(1) ? res_hi : hi;
      lo_n = cnt == CW'(1) ? res_lo : lo;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      res_hi <= res_hi_n;
      res_lo <= res_lo_n;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
  assign md.busy = state == RUN;
  assign md.hi = hi;
  assign md.lo = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO and busy-length checks.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int n;
  logic held;
  mult_div_unit_if md();
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = 1'b1;
    md.mdOp = op;
    md.opA = a;
    md.opB = b;
    @(negedge clk);
    md.start = 1'b0;
    md.mdOp = 3'd0;
  endtask

  task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ncyc, input logic [31:0] ehi, input logic [31:0] elo, input logic jitter);
    logic [31:0] ohi, olo;
    ohi = md.hi;
    olo = md.lo;
    issue(op, a, b);
    n = 0;
    held = 1'b1;
    while (md.busy && n < 50) begin
      n++;
      if (md.hi !== ohi || md.lo !== olo) held = 1'b0;
      if (jitter) begin
        md.opA = $urandom();
        md.opB = $urandom();
      end
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(ncyc));
    chk({tag, " hi/lo held while busy"}, {31'd0, held}, 32'd1);
    chk({tag, " hi"}, md.hi, ehi);
    chk({tag, " lo"}, md.lo, elo);
  endtask

  initial begin
    md.start = 1'b0;
    md.mdOp = 3'd0;
    md.opA = 32'd0;
    md.opB = 32'd0;
    @(negedge clk);
    chk("reset busy", {31'd0, md.busy}, 32'd0);
    chk("reset hi", md.hi, 32'd0);
    chk("reset lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_long("MULT -1*2", 3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_long("MULTU ffffffff*2", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_long("DIV -7/2", 3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_long("DIVU 7/0", 3'd4, 32'h7, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_long("DIV min/-1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 1'b0);
    md.start = 1'b1;
    md.mdOp = 3'd5;
    md.opA = 32'h12345678;
    @(negedge clk);
    chk("MTHI hi", md.hi, 32'h12345678);
    chk("MTHI lo untouched", md.lo, 32'h80000000);
    chk("MTHI busy", {31'd0, md.busy}, 32'd0);
    md.mdOp = 3'd6;
    md.opA = 32'h9ABCDEF0;
    @(negedge clk);
    md.start = 1'b0;
    md.mdOp = 3'd0;
    chk("MTLO lo", md.lo, 32'h9ABCDEF0);
    chk("MTLO hi kept", md.hi, 32'h12345678);
    chk("MTLO busy", {31'd0, md.busy}, 32'd0);
    run_long("MULT 3*4 jitter", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);
    issue(3'd4, 32'd100, 32'd7);
    chk("DIVU busy start", {31'd0, md.busy}, 32'd1);
    md.start = 1'b1;
    md.mdOp = 3'd1;
    md.opA = 32'd5;
    md.opB = 32'd5;
    @(negedge clk);
    md.mdOp = 3'd6;
    md.opA = 32'hDEADBEEF;
    @(negedge clk);
    md.start = 1'b0;
    md.mdOp = 3'd0;
    chk("ignored MTLO", md.lo, 32'd12);
    n = 2;
    while (md.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("DIVU busy cycles", 32'(n), 32'd10);
    chk("DIVU 100/7 hi", md.hi, 32'd2);
    chk("DIVU 100/7 lo", md.lo, 32'd14);
    run_long("MULT zero gap", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    chk("mid DIV busy", {31'd0, md.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", {31'd0, md.busy}, 32'd0);
    chk("async reset hi", md.hi, 32'd0);
    chk("async reset lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("aborted busy", {31'd0, md.busy}, 32'd0);
    chk("aborted hi", md.hi, 32'd0);
    chk("aborted lo", md.lo, 32'd0);
    run_long("MULT after reset", 3'd1, 32'd3, 32'd5, 5, 32'd0, 32'd15, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
